// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings, forwarded-control bundle and master-port state type
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {IDLE, WAIT_GRANT, DATA, ERR1, ERR2} port_state_t;
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic [1:0] trans;
    logic       lock;
  } ahb_ctrl_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb3lite_interconnect_master_port_if.sv
// ahb3lite_interconnect_master_port_if: AHB3-Lite bus between one master and its switch ingress port
interface ahb3lite_interconnect_master_port_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;
  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_interconnect_addr_decoder.sv
// ahb3lite_interconnect_addr_decoder: address to one-hot slave select; lowest matching index wins
module ahb3lite_interconnect_addr_decoder
  import ahb3lite_pkg::*;
#(
  parameter  int HADDR_SIZE = 32,
  parameter  int SLAVES     = 8,
  localparam int SW         = idx_width(SLAVES)
) (
  input  logic [HADDR_SIZE-1:0] addr_i,
  input  logic [HADDR_SIZE-1:0] slv_base_i [SLAVES],
  input  logic [HADDR_SIZE-1:0] slv_mask_i [SLAVES],
  output logic [SLAVES-1:0]     sel_o,
  output logic [SW-1:0]         idx_o,
  output logic                  no_hit_o
);
  // scan from the top so the lowest matching slave is the one left standing
  always_comb begin
    idx_o    = '0;
    no_hit_o = 1'b1;
    for (int s = SLAVES - 1; s >= 0; s--)
      if ((addr_i & slv_mask_i[s]) == (slv_base_i[s] & slv_mask_i[s])) begin
        idx_o    = SW'(s);
        no_hit_o = 1'b0;
      end
    sel_o = no_hit_o ? '0 : SLAVES'(1) << idx_o;
  end
endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// ahb3lite_interconnect_master_port: per-master ingress of the AHB3-Lite switch; decodes, holds ungranted
// address phases and returns the addressed slave's response. Option: AHB3LITE_IC_SEQ2NONSEQ_EN rewrites
// SEQ to NONSEQ on the first beat after a grant wait or a slave crossing.
module ahb3lite_interconnect_master_port
  import ahb3lite_pkg::*;
#(
  parameter  int HADDR_SIZE = 32,
  parameter  int HDATA_SIZE = 32,
  parameter  int MASTERS    = 3,
  parameter  int SLAVES     = 8,
  localparam int PW         = idx_width(MASTERS),
  localparam int SW         = idx_width(SLAVES)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [PW-1:0]         mst_priority_i,
  output logic [PW-1:0]         mst_priority_o,
  ahb3lite_interconnect_master_port_if.slave mst,
  input  logic [HADDR_SIZE-1:0] slv_base [SLAVES],
  input  logic [HADDR_SIZE-1:0] slv_mask [SLAVES],
  output logic [SLAVES-1:0]     slvHSEL,
  output logic [HADDR_SIZE-1:0] slvHADDR,
  output logic [HDATA_SIZE-1:0] slvHWDATA,
  output logic                  slvHWRITE,
  output logic [2:0]            slvHSIZE,
  output logic [2:0]            slvHBURST,
  output logic [3:0]            slvHPROT,
  output logic [1:0]            slvHTRANS,
  output logic                  slvHMASTLOCK,
  output logic                  slvHREADY,
  input  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES],
  input  logic [SLAVES-1:0]     slvHREADYOUT,
  input  logic [SLAVES-1:0]     slvHRESP,
  input  logic [SLAVES-1:0]     granted,
  output logic [SLAVES-1:0]     can_switch
);
  port_state_t           state_q, state_d;
  logic [SW-1:0]         dphase_slv_q, dphase_slv_d, hold_slv_q, dec_idx;
  logic [HADDR_SIZE-1:0] haddr_q;
  ahb_ctrl_t             ctrl_q, live_ctrl, cur_ctrl;
  logic [SLAVES-1:0]     dec_sel;
  logic                  no_hit, decode_en, acc, load, use_latch;

  ahb3lite_interconnect_addr_decoder #(.HADDR_SIZE(HADDR_SIZE), .SLAVES(SLAVES)) u_dec (
    .addr_i    (mst.HADDR),
    .slv_base_i(slv_base),
    .slv_mask_i(slv_mask),
    .sel_o     (dec_sel),
    .idx_o     (dec_idx),
    .no_hit_o  (no_hit)
  );

  assign mst_priority_o = mst_priority_i;
  assign live_ctrl = '{mst.HWRITE, mst.HSIZE, mst.HBURST, mst.HPROT, mst.HTRANS, mst.HMASTLOCK};
  assign decode_en = state_q inside {IDLE, DATA, ERR2};
  assign acc       = decode_en & mst.HSEL & mst.HTRANS[1] & mst.HREADY;
  assign load      = acc & ~no_hit & ~granted[dec_idx];
  assign use_latch = state_q == WAIT_GRANT;
  assign cur_ctrl  = use_latch ? ctrl_q : live_ctrl;

  assign slvHSEL      = use_latch ? SLAVES'(1) << hold_slv_q :
                        (decode_en && mst.HSEL && mst.HTRANS != HTRANS_IDLE) ? dec_sel : '0;
  assign slvHADDR     = use_latch ? haddr_q : mst.HADDR;
  assign slvHWDATA    = mst.HWDATA;
  assign slvHWRITE    = cur_ctrl.write;
  assign slvHSIZE     = cur_ctrl.size;
  assign slvHBURST    = cur_ctrl.burst;
  assign slvHPROT     = cur_ctrl.prot;
  assign slvHMASTLOCK = cur_ctrl.lock;
  assign slvHREADY    = use_latch ? granted[hold_slv_q] : mst.HREADY;
  assign can_switch   = ~(slvHSEL & {SLAVES{cur_ctrl.lock | (cur_ctrl.trans inside {HTRANS_SEQ, HTRANS_BUSY})}});

  assign mst.HRDATA    = slvHRDATA[dphase_slv_q];
  assign mst.HREADYOUT = state_q == DATA ? slvHREADYOUT[dphase_slv_q] : state_q inside {IDLE, ERR2};
  assign mst.HRESP     = state_q == DATA ? slvHRESP[dphase_slv_q] :
                         (state_q inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;

`ifdef AHB3LITE_IC_SEQ2NONSEQ_EN
  logic [SW-1:0] last_slv_q;
  // remember which slave the previous accepted beat went to, to spot crossings
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) last_slv_q <= '0;
    else if (acc && !no_hit) last_slv_q <= dec_idx;
  assign slvHTRANS = (cur_ctrl.trans == HTRANS_SEQ && (use_latch || dec_idx != last_slv_q)) ? HTRANS_NONSEQ
                                                                                           : cur_ctrl.trans;
`else
  assign slvHTRANS = cur_ctrl.trans;
`endif

  // next state: grant wait resolves on the held slave's grant, error response takes two cycles
  always_comb begin
    state_d      = state_q;
    dphase_slv_d = dphase_slv_q;
    if (use_latch) begin
      if (granted[hold_slv_q]) begin
        state_d      = DATA;
        dphase_slv_d = hold_slv_q;
      end
    end else if (state_q == ERR1) state_d = ERR2;
    else if (acc) begin
      state_d      = no_hit ? ERR1 : granted[dec_idx] ? DATA : WAIT_GRANT;
      dphase_slv_d = dec_idx;
    end else if (!(state_q == DATA && !mst.HREADY)) state_d = IDLE;
  end

  // state, data-phase owner and the held address phase of an ungranted transfer
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q      <= IDLE;
      dphase_slv_q <= '0;
      hold_slv_q   <= '0;
      haddr_q      <= '0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      dphase_slv_q <= dphase_slv_d;
      if (load) begin
        hold_slv_q <= dec_idx;
        haddr_q    <= mst.HADDR;
        ctrl_q     <= live_ctrl;
      end
    end
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// tb_ahb3lite_interconnect_master_port: directed bench for the switch master port
module tb_ahb3lite_interconnect_master_port;
  import ahb3lite_pkg::*;
  localparam int S = 8;
`ifdef AHB3LITE_IC_SEQ2NONSEQ_EN
  localparam logic [1:0] XTRANS = HTRANS_NONSEQ;
`else
  localparam logic [1:0] XTRANS = HTRANS_SEQ;
`endif
  logic          HCLK = 1'b0, HRESETn = 1'b0;
  logic [1:0]    prio_i, prio_o;
  logic [31:0]   base [S], mask [S], rdata [S];
  logic [S-1:0]  sel, rdy, resp, granted, can_sw;
  logic [31:0]   s_addr, s_wdata;
  logic          s_write, s_lock, s_ready;
  logic [2:0]    s_size, s_burst;
  logic [3:0]    s_prot;
  logic [1:0]    s_trans;
  int            tests = 0, fails = 0, waits = 0;

  ahb3lite_interconnect_master_port_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) mst ();
  assign mst.HREADY = mst.HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb3lite_interconnect_master_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(3), .SLAVES(S)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mst_priority_i(prio_i), .mst_priority_o(prio_o), .mst(mst),
    .slv_base(base), .slv_mask(mask), .slvHSEL(sel), .slvHADDR(s_addr), .slvHWDATA(s_wdata),
    .slvHWRITE(s_write), .slvHSIZE(s_size), .slvHBURST(s_burst), .slvHPROT(s_prot), .slvHTRANS(s_trans),
    .slvHMASTLOCK(s_lock), .slvHREADY(s_ready), .slvHRDATA(rdata), .slvHREADYOUT(rdy), .slvHRESP(resp),
    .granted(granted), .can_switch(can_sw)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic hs, input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
    mst.HSEL = hs; mst.HTRANS = tr; mst.HADDR = a; mst.HWRITE = w; mst.HMASTLOCK = lk;
  endtask

  initial begin
    prio_i = 2'd2; granted = '0; rdy = '1; resp = '0;
    for (int s = 0; s < S; s++) begin
      base[s]  = 32'(s) << 12;
      mask[s]  = 32'h0000_F000;
      rdata[s] = 32'hD000_0000 | 32'(s);
    end
    drive(0, HTRANS_IDLE, 0, 0, 0);
    mst.HWDATA = '0; mst.HSIZE = 3'd2; mst.HBURST = 3'd0; mst.HPROT = 4'h3;
    #12;
    chk("rst_hreadyout", mst.HREADYOUT, 1);
    chk("rst_hresp", mst.HRESP, 0);
    chk("rst_slvhsel", sel, 0);
    chk("rst_can_switch", can_sw, 8'hFF);
    chk("prio_pass", prio_o, 2);
    @(negedge HCLK) HRESETn = 1'b1;
    tick;
    // granted read: zero added latency
    granted = 8'h02; drive(1, HTRANS_NONSEQ, 32'h1004, 0, 0); #1;
    chk("g_slvhsel", sel, 8'h02);
    chk("g_slvhaddr", s_addr, 32'h1004);
    chk("g_slvhtrans", s_trans, HTRANS_NONSEQ);
    chk("g_can_switch", can_sw, 8'hFF);
    chk("g_hreadyout_a", mst.HREADYOUT, 1);
    tick;
    drive(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("g_hrdata", mst.HRDATA, 32'hD000_0001);
    chk("g_hreadyout_d", mst.HREADYOUT, 1);
    chk("g_hresp_d", mst.HRESP, 0);
    tick;
    // held write: grant arrives after three ungranted wait cycles
    granted = 8'h00; drive(1, HTRANS_NONSEQ, 32'h1004, 1, 0); #1;
    chk("h_req_live", sel, 8'h02);
    chk("h_slvhready_a", s_ready, 1);
    tick;
    drive(0, HTRANS_IDLE, 32'h0000_3000, 0, 0); mst.HWDATA = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      granted = (i == 3) ? 8'h02 : 8'h00; #1;
      if (mst.HREADYOUT === 1'b0) waits++;
      chk("h_held_addr", s_addr, 32'h1004);
      chk("h_held_sel", sel, 8'h02);
      chk("h_held_write", s_write, 1);
      chk("h_slvhready", s_ready, i == 3);
      tick;
    end
    chk("h_wait_cycles", waits, 4);
    chk("h_wdata", s_wdata, 32'hCAFE_F00D);
    chk("h_hreadyout_d", mst.HREADYOUT, 1);
    chk("h_hrdata", mst.HRDATA, 32'hD000_0001);
    tick;
    // decode miss: two-cycle error response, no slave selected
    granted = '1; drive(1, HTRANS_NONSEQ, 32'h0000_F000, 0, 0); #1;
    chk("e_slvhsel_a", sel, 0);
    tick;
    drive(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("e1_hreadyout", mst.HREADYOUT, 0);
    chk("e1_hresp", mst.HRESP, 1);
    chk("e1_slvhsel", sel, 0);
    tick;
    chk("e2_hreadyout", mst.HREADYOUT, 1);
    chk("e2_hresp", mst.HRESP, 1);
    tick;
    chk("e_idle_hresp", mst.HRESP, 0);
    // locked 4-beat INCR burst to slave 2 with one slave wait state
    granted = 8'h04; drive(1, HTRANS_NONSEQ, 32'h2000, 1, 1); mst.HBURST = 3'b011; #1;
    chk("l_b0_can_switch", can_sw, 8'hFB);
    chk("l_b0_sel", sel, 8'h04);
    tick;
    drive(1, HTRANS_SEQ, 32'h2004, 1, 1); rdy[2] = 1'b0; #1;
    chk("l_stall_hreadyout", mst.HREADYOUT, 0);
    chk("l_stall_can_switch", can_sw, 8'hFB);
    tick;
    rdy[2] = 1'b1; #1;
    chk("l_b1_hreadyout", mst.HREADYOUT, 1);
    chk("l_b1_can_switch", can_sw, 8'hFB);
    tick;
    drive(1, HTRANS_SEQ, 32'h2008, 1, 1); #1;
    chk("l_b2_can_switch", can_sw, 8'hFB);
    tick;
    drive(1, HTRANS_SEQ, 32'h200C, 1, 1); #1;
    chk("l_b3_can_switch", can_sw, 8'hFB);
    tick;
    drive(0, HTRANS_IDLE, 0, 0, 0); mst.HBURST = 3'd0; #1;
    chk("l_end_can_switch", can_sw, 8'hFF);
    chk("l_end_hrdata", mst.HRDATA, 32'hD000_0002);
    tick;
    // SEQ beat crossing into ungranted slave 2
    granted = 8'h02; drive(1, HTRANS_NONSEQ, 32'h1FFC, 0, 0); #1;
    tick;
    drive(1, HTRANS_SEQ, 32'h2000, 0, 0); #1;
    chk("x_sel", sel, 8'h04);
    chk("x_slvhtrans_live", s_trans, XTRANS);
    chk("x_can_switch", can_sw, 8'hFB);
    chk("x_hreadyout", mst.HREADYOUT, 1);
    tick;
    drive(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("x_wait_hreadyout", mst.HREADYOUT, 0);
    chk("x_slvhtrans_held", s_trans, XTRANS);
    chk("x_held_sel", sel, 8'h04);
    // asynchronous reset while waiting for the grant
    HRESETn = 1'b0; #1;
    chk("r_async_hreadyout", mst.HREADYOUT, 1);
    chk("r_async_slvhsel", sel, 0);
    @(negedge HCLK) HRESETn = 1'b1;
    tick;
    chk("r_hreadyout", mst.HREADYOUT, 1);
    chk("r_slvhsel", sel, 0);
    chk("r_can_switch", can_sw, 8'hFF);
    granted = 8'h02; drive(1, HTRANS_NONSEQ, 32'h1008, 0, 0); #1;
    chk("r_live_sel", sel, 8'h02);
    chk("r_live_addr", s_addr, 32'h1008);
    tick;
    drive(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("r_data_hreadyout", mst.HREADYOUT, 1);
    chk("r_data_hrdata", mst.HRDATA, 32'hD000_0001);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
